squarer: RTL and testbench
==========================

// Module: squarer
//
// PURPOSE
//   Registered 3-bit unsigned squarer: Y = A*A, where A = {a2,a1,a0} (a0 = LSB)
//   and Y = {y5,y4,y3,y2,y1,y0} (y0 = LSB).
//   Small arithmetic leaf used by datapath blocks that need x^2 of a 3-bit operand.
//   The product is computed combinationally and delivered through a pipeline of
//   LATENCY register stages, with a valid flag travelling alongside it.
//
// PARAMETERS
//   LATENCY  1  register stages from inputs to outputs; legal values 1..4
//
// PORTS
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous, active-high reset
//   in_valid   in   1  a2..a0 carry a valid operand this cycle
//   a0         in   1  operand bit 0 (LSB)
//   a1         in   1  operand bit 1
//   a2         in   1  operand bit 2 (MSB)
//   out_valid  out  1  y5..y0 hold a valid result
//   y0         out  1  square bit 0 (LSB)
//   y1         out  1  square bit 1
//   y2         out  1  square bit 2
//   y3         out  1  square bit 3
//   y4         out  1  square bit 4
//   y5         out  1  square bit 5 (MSB)
//
// BEHAVIOUR
//   - Arithmetic: unsigned, Y = A*A, exact; full range 0..49 fits in 6 bits, so no
//     overflow or saturation is possible.
//   - Required mapping A->Y:
//     0->0, 1->1, 2->4, 3->9, 4->16, 5->25, 6->36, 7->49.
//   - Structural invariants:
//     - y1 is always 0.
//     - y0 always equals a0 of the same operand.
//   - Latency: the operand sampled at clock edge N appears on y5..y0 after edge
//     N+LATENCY-1, i.e. exactly LATENCY edges after it was applied.
//   - Throughput: one new operand every cycle; no stall or backpressure.
//   - in_valid is delayed by the same pipeline to form out_valid.
//   - Data registers load on every edge regardless of in_valid. When out_valid=0,
//     y5..y0 are don't-care to consumers.
//   - Reset: while rst=1, all pipeline stages clear asynchronously:
//     - out_valid=0 and y5..y0=0 immediately, without waiting for a clock edge.
//   - Reset deasserted: the first valid result appears LATENCY edges after the
//     first in_valid=1 sample.
//   - Reset asserted mid-stream: every in-flight result is discarded and nothing
//     is replayed.
//   - X/Z on a2..a0 while in_valid=0 must not propagate to out_valid.
//
// CONFIGURATION
//   SQUARER_PARITY_EN
//   - Defined:
//     - adds output port y_par (1 bit) = y5^y4^y3^y2^y1^y0.
//     - y_par is registered with identical latency and alignment to y5..y0.
//     - y_par resets to 0.
//   - Undefined:
//     - y_par port is absent.
//     - The rest of the behaviour is unchanged.
//
// TESTING
//   - Exhaustive sweep, LATENCY=1: apply A=0..7 in order, one per cycle, with
//     in_valid=1.
//     -> Y = 0,1,4,9,16,25,36,49 on the following cycles; out_valid=1 throughout.
//   - Single operands:
//     -> a0=1,a1=0,a2=0 gives Y=000001.
//     -> a2=1 only gives Y=010000.
//     -> a0=a1=a2=1 gives Y=110001.
//   - Async reset: stream A=7 continuously, then raise rst between clock edges.
//     -> Y=0 and out_valid=0 before the next edge.
//     -> After rst falls, out_valid returns LATENCY edges after in_valid=1.
//   - Latency, LATENCY=3: a single in_valid pulse with A=5.
//     -> out_valid is high for exactly one cycle, 3 edges later, with Y=25.
//     -> out_valid=0 at all other times.
//   - Invariant check: random operands with random in_valid over 1000 cycles.
//     -> Y equals the square of the operand delayed by LATENCY.
//     -> y1=0 always; y0 equals the delayed a0.
//   - With SQUARER_PARITY_EN defined:
//     -> A=3 gives Y=9 and y_par=0.
//     -> A=6 gives Y=36 and y_par=0.
//     -> A=7 gives Y=49 and y_par=1.

Source files
------------

// File: rtl/squarer.sv
// ----------------------------------------------------------------------------
// squarer -- registered 3-bit unsigned squarer, Y = A*A
//
// A = {a2,a1,a0} (a0 = LSB), Y = {y5,y4,y3,y2,y1,y0} (y0 = LSB).
// The square is formed combinationally from a handful of gates and then
// carried through LATENCY register stages together with a valid flag.
//
// Parameters
//   LATENCY    register stages from operand to result, legal range 1..4.
//              Values outside the range are clamped to the nearest legal one.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset, clears every stage
//   in_valid   in   a2..a0 carry a valid operand this cycle
//   a0..a2     in   operand bits (a0 = LSB)
//   out_valid  out  y5..y0 hold a valid result
//   y0..y5     out  square bits (y0 = LSB)
//   y_par      out  (only with SQUARER_PARITY_EN) XOR of y5..y0, same timing
//
// Optional feature
//   Define SQUARER_PARITY_EN to add the y_par output.
// ----------------------------------------------------------------------------
module squarer #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  output logic out_valid,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3,
  output logic y4,
  output logic y5
`ifdef SQUARER_PARITY_EN
  ,
  output logic y_par
`endif
);

  localparam int STAGES = (LATENCY < 1) ? 1 : ((LATENCY > 4) ? 4 : LATENCY);

  // --------------------------------------------------------------------------
  // Combinational square.
  //   A : Y
  //   0 : 000000   4 : 010000
  //   1 : 000001   5 : 011001
  //   2 : 000100   6 : 100100
  //   3 : 001001   7 : 110001
  // Bit 0 is always a0 and bit 1 is always 0 (odd squares are 1 mod 8,
  // even squares are 0 mod 4), which leaves four small product terms.
  // --------------------------------------------------------------------------
  logic [5:0] sq_comb;

  always_comb begin
    sq_comb    = '0;
    sq_comb[0] = a0;
    sq_comb[1] = 1'b0;
    sq_comb[2] = a1 & ~a0;
    sq_comb[3] = a0 & (a1 ^ a2);
    sq_comb[4] = a2 & (a0 | ~a1);
    sq_comb[5] = a2 & a1;
  end

`ifdef SQUARER_PARITY_EN
  // Parity is computed from the unregistered square so that it rides in the
  // same stages as the data and stays aligned with it.
  logic par_comb;
  assign par_comb = ^sq_comb;
`endif

  // --------------------------------------------------------------------------
  // Pipeline. Data loads every edge regardless of in_valid; only the valid
  // flag decides whether a stage holds something meaningful. Keeping the
  // valid chain free of any data term means an undefined operand can never
  // leak into out_valid.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [5:0] data_in;
      logic       valid_in;
      logic [5:0] data_reg;
      logic       valid_reg;

      if (gi == 0) begin : g_head
        assign data_in  = sq_comb;
        assign valid_in = in_valid;
      end else begin : g_body
        assign data_in  = g_stage[gi-1].data_reg;
        assign valid_in = g_stage[gi-1].valid_reg;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          data_reg  <= data_in;
          valid_reg <= valid_in;
        end
      end

`ifdef SQUARER_PARITY_EN
      logic par_in;
      logic par_reg;

      if (gi == 0) begin : g_par_head
        assign par_in = par_comb;
      end else begin : g_par_body
        assign par_in = g_stage[gi-1].par_reg;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          par_reg <= 1'b0;
        end else begin
          par_reg <= par_in;
        end
      end
`endif
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs from the last stage.
  // --------------------------------------------------------------------------
  assign out_valid = g_stage[STAGES-1].valid_reg;
  assign y0        = g_stage[STAGES-1].data_reg[0];
  assign y1        = g_stage[STAGES-1].data_reg[1];
  assign y2        = g_stage[STAGES-1].data_reg[2];
  assign y3        = g_stage[STAGES-1].data_reg[3];
  assign y4        = g_stage[STAGES-1].data_reg[4];
  assign y5        = g_stage[STAGES-1].data_reg[5];

`ifdef SQUARER_PARITY_EN
  assign y_par = g_stage[STAGES-1].par_reg;
`endif

endmodule

// File: tb/tb_squarer.sv
// ----------------------------------------------------------------------------
// tb_squarer -- bench for squarer.
// Two instances share the same stimulus: one with LATENCY=1 and one with
// LATENCY=3. Every valid operand pushes an expected record (value, parity,
// due cycle) onto a per-instance queue; each cycle the outputs are sampled on
// the falling clock edge and matched against the queue head.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_squarer;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic a0, a1, a2;

  logic ov1, ov3;
  logic [5:0] y_1, y_3;
  logic par1, par3;

  always #5 clk = ~clk;

  squarer #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a0(a0), .a1(a1), .a2(a2),
    .out_valid(ov1),
    .y0(y_1[0]), .y1(y_1[1]), .y2(y_1[2]), .y3(y_1[3]), .y4(y_1[4]), .y5(y_1[5])
`ifdef SQUARER_PARITY_EN
    , .y_par(par1)
`endif
  );

  squarer #(.LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a0(a0), .a1(a1), .a2(a2),
    .out_valid(ov3),
    .y0(y_3[0]), .y1(y_3[1]), .y2(y_3[2]), .y3(y_3[3]), .y4(y_3[4]), .y5(y_3[5])
`ifdef SQUARER_PARITY_EN
    , .y_par(par3)
`endif
  );

`ifndef SQUARER_PARITY_EN
  assign par1 = 1'b0;
  assign par3 = 1'b0;
`endif

  // Posedge counter; outputs are checked at the falling edge after it moves.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0] y;
    logic       par;
    logic [2:0] a;
    int         due;
  } sb_t;

  sb_t q1[$];
  sb_t q3[$];

  typedef struct {
    logic [2:0] a;
    logic [5:0] y;
    logic       par;
  } vec_t;

  vec_t tbl[14];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference squares written out as constants.
  int sq_lut[8] = '{0, 1, 4, 9, 16, 25, 36, 49};

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endtask

  // Match one instance's outputs against its queue head.
  task automatic check_dut(input int idx, input logic ov, input logic [5:0] y, input logic par);
    sb_t head;
    logic have;
    string tag;
    tag  = (idx == 0) ? "L1" : "L3";
    have = 1'b0;
    if (idx == 0) begin
      if (q1.size() > 0) begin have = 1'b1; head = q1[0]; end
    end else begin
      if (q3.size() > 0) begin have = 1'b1; head = q3[0]; end
    end

    if (ov === 1'b1) begin
      if (!have) begin
        chk({tag, " unexpected_out_valid"}, 1, 0);
      end else begin
        if (idx == 0) void'(q1.pop_front()); else void'(q3.pop_front());
        chk({tag, " due_cycle"}, cyc, head.due);
        chk({tag, " y"}, int'(y), int'(head.y));
        chk({tag, " y1_zero"}, int'(y[1]), 0);
        chk({tag, " y0_eq_a0"}, int'(y[0]), int'(head.a[0]));
`ifdef SQUARER_PARITY_EN
        chk({tag, " y_par"}, int'(par), int'(head.par));
`endif
      end
    end else if (have && head.due <= cyc) begin
      if (idx == 0) void'(q1.pop_front()); else void'(q3.pop_front());
      chk({tag, " missing_out_valid"}, 0, 1);
    end
  endtask

  // Apply one operand at the falling edge, run one clock, check both outputs.
  task automatic step(input logic v, input logic [2:0] a, input logic [5:0] exp_y, input logic exp_par);
    sb_t e;
    in_valid = v;
    {a2, a1, a0} = a;
    if (v) begin
      e.y = exp_y; e.par = exp_par; e.a = a;
      e.due = cyc + 1; q1.push_back(e);
      e.due = cyc + 3; q3.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    $display("cyc %0d in_valid=%0b a=%0d | L1 ov=%0b y=%0d | L3 ov=%0b y=%0d",
             cyc, v, a, ov1, y_1, ov3, y_3);
    check_dut(0, ov1, y_1, par1);
    check_dut(1, ov3, y_3, par3);
  endtask

  task automatic step_op(input logic v, input logic [2:0] a);
    logic [5:0] ey;
    ey = 6'(sq_lut[a]);
    step(v, a, ey, ^ey);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 6'd0, 1'b0);
  endtask

  initial begin
    int pulse_hi;

    // Sweep 0..7 followed by the single-operand and parity cases.
    tbl[0]  = '{3'd0, 6'b000000, 1'b0};
    tbl[1]  = '{3'd1, 6'b000001, 1'b1};
    tbl[2]  = '{3'd2, 6'b000100, 1'b1};
    tbl[3]  = '{3'd3, 6'b001001, 1'b0};
    tbl[4]  = '{3'd4, 6'b010000, 1'b1};
    tbl[5]  = '{3'd5, 6'b011001, 1'b1};
    tbl[6]  = '{3'd6, 6'b100100, 1'b0};
    tbl[7]  = '{3'd7, 6'b110001, 1'b1};
    tbl[8]  = '{3'd1, 6'b000001, 1'b1};
    tbl[9]  = '{3'd4, 6'b010000, 1'b1};
    tbl[10] = '{3'd7, 6'b110001, 1'b1};
    tbl[11] = '{3'd3, 6'd9,      1'b0};
    tbl[12] = '{3'd6, 6'd36,     1'b0};
    tbl[13] = '{3'd7, 6'd49,     1'b1};

    rst = 1'b1; in_valid = 1'b0; a0 = 1'b0; a1 = 1'b0; a2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset L1 out_valid", int'(ov1), 0);
    chk("reset L1 y",         int'(y_1), 0);
    chk("reset L3 out_valid", int'(ov3), 0);
    chk("reset L3 y",         int'(y_3), 0);
`ifdef SQUARER_PARITY_EN
    chk("reset L1 y_par", int'(par1), 0);
    chk("reset L3 y_par", int'(par3), 0);
`endif
    rst = 1'b0;
    idle(2);

    // Back-to-back table vectors; any gap in out_valid is caught as missing.
    for (int i = 0; i < 14; i++) step(1'b1, tbl[i].a, tbl[i].y, tbl[i].par);
    idle(4);

    // Single pulse A=5: exactly one valid cycle on the LATENCY=3 output.
    pulse_hi = 0;
    step_op(1'b1, 3'd5);
    if (ov3 === 1'b1) pulse_hi++;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (ov3 === 1'b1) pulse_hi++;
    end
    chk("L3 pulse out_valid cycles", pulse_hi, 1);

    // Asynchronous reset in the middle of a stream of A=7.
    for (int i = 0; i < 5; i++) step_op(1'b1, 3'd7);
    #2 rst = 1'b1;
    #1;
    chk("async rst L1 out_valid", int'(ov1), 0);
    chk("async rst L1 y",         int'(y_1), 0);
    chk("async rst L3 out_valid", int'(ov3), 0);
    chk("async rst L3 y",         int'(y_3), 0);
    q1.delete();
    q3.delete();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("held rst L3 out_valid", int'(ov3), 0);
    rst = 1'b0;
    idle(1);
    step_op(1'b1, 3'd7);
    idle(4);

    // Random operands with random in_valid.
    for (int i = 0; i < 1000; i++) begin
      step_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    idle(5);

    chk("L1 queue drained", q1.size(), 0);
    chk("L3 queue drained", q3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
